// File: rtl/hwce_maxpool.sv
// rtl/hwce_maxpool.sv - 2x2 signed max pooling with line buffer and 2-entry output FIFO
// Optional saturating drop counter enabled by HWCE_MAXPOOL_DROP_CNT_EN.
module hwce_maxpool #(
  parameter int CONV_WIDTH  = 16,
  parameter int NPX         = 2,
  parameter int MAX_ROW_LEN = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    row_len,
  input  logic [NPX*CONV_WIDTH-1:0]     y_in,
  input  logic                          valid_y_in,
  output logic [(NPX/2)*CONV_WIDTH-1:0] y_out,
  output logic                          valid_y_out,
  input  logic                          ready_y_out,
  output logic [15:0]                   drop_cnt
);

  localparam int W  = CONV_WIDTH;
  localparam int OW = (NPX / 2) * CONV_WIDTH;
  localparam int AW = (MAX_ROW_LEN > 1) ? $clog2(MAX_ROW_LEN) : 1;

  typedef enum logic {EVEN_ROW, ODD_ROW} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   col_q, col_d;
  logic [7:0]      row_len_q;
  logic [7:0]      len_clamped;

  logic            eff_even;
  logic [AW-1:0]   eff_col;
  logic [7:0]      eff_len;
  logic            last_col;

  logic [OW-1:0]   hmax;
  logic [OW-1:0]   pooled;
  logic [OW-1:0]   lb_rd;
  logic [OW-1:0]   lb_q [MAX_ROW_LEN];

  logic signed [W-1:0] pa, pb, ph, pl;

  logic [OW-1:0]   fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      cnt_q;
  logic            push, pop, push_ok;

  always_comb begin
    len_clamped = row_len;
    if (row_len == 8'd0) begin
      len_clamped = 8'd1;
    end else if (32'(row_len) > MAX_ROW_LEN) begin
      len_clamped = 8'(MAX_ROW_LEN);
    end
  end

  // A start coinciding with a beat makes that beat col 0 of an even row.
  assign eff_even = start || (state_q == EVEN_ROW);
  assign eff_col  = start ? '0 : col_q;
  assign eff_len  = start ? len_clamped : row_len_q;
  assign last_col = (8'(eff_col) == (eff_len - 8'd1));
  assign lb_rd    = lb_q[eff_col];

  always_comb begin
    hmax   = '0;
    pooled = '0;
    pa     = '0;
    pb     = '0;
    ph     = '0;
    pl     = '0;
    for (int k = 0; k < NPX / 2; k++) begin
      pa = y_in[(2*k)*W +: W];
      pb = y_in[(2*k+1)*W +: W];
      ph = (pa > pb) ? pa : pb;
      pl = lb_rd[k*W +: W];
      hmax[k*W +: W]   = ph;
      pooled[k*W +: W] = (ph > pl) ? ph : pl;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (start) begin
      state_d = EVEN_ROW;
      col_d   = '0;
    end
    if (valid_y_in) begin
      if (last_col) begin
        col_d   = '0;
        state_d = eff_even ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d   = eff_col + AW'(1);
        state_d = eff_even ? EVEN_ROW : ODD_ROW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= EVEN_ROW;
      col_q     <= '0;
      row_len_q <= 8'd1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (start) begin
        row_len_q <= len_clamped;
      end
    end
  end

  // Line buffer holds even-row horizontal maxima; intentionally not reset.
  always_ff @(posedge clk) begin
    if (valid_y_in && eff_even) begin
      lb_q[eff_col] <= hmax;
    end
  end

  assign push    = valid_y_in && !eff_even;
  assign pop     = (cnt_q != 2'd0) && ready_y_out;
  assign push_ok = push && ((cnt_q != 2'd2) || pop);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= pooled;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign valid_y_out = (cnt_q != 2'd0);
  assign y_out       = valid_y_out ? fifo_q[rd_ptr_q] : '0;

`ifdef HWCE_MAXPOOL_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop;

  assign drop = push && !push_ok;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      drop_cnt_q <= 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hwce_maxpool.sv
// tb/tb_hwce_maxpool.sv - directed self-checking bench for hwce_maxpool
module tb_hwce_maxpool;

`ifdef HWCE_MAXPOOL_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  row_len;
  logic [31:0] y_in;
  logic        valid_y_in;
  logic [15:0] y_out;
  logic        valid_y_out;
  logic        ready_y_out;
  logic [15:0] drop_cnt;

  int total;
  int bad;

  hwce_maxpool #(.CONV_WIDTH(16), .NPX(2), .MAX_ROW_LEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_len     (row_len),
    .y_in        (y_in),
    .valid_y_in  (valid_y_in),
    .y_out       (y_out),
    .valid_y_out (valid_y_out),
    .ready_y_out (ready_y_out),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic st, input logic [7:0] len, input logic v,
                     input logic [15:0] p0, input logic [15:0] p1, input logic rdy);
    start       = st;
    row_len     = len;
    valid_y_in  = v;
    y_in        = {p1, p0};
    ready_y_out = rdy;
    @(negedge clk);
    start      = 1'b0;
    valid_y_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (valid_y_out !== 1'b0 || y_out !== 16'h0 || drop_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_state valid=%b y=%h drop=%h want 0/0000/0000", valid_y_out, y_out, drop_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cyc(1, 2, 0, 16'h0, 16'h0, 1);
    cyc(0, 2, 1, 16'd1, 16'd5, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_even_no_out valid=%b want 0", valid_y_out);
    end
    cyc(0, 2, 1, 16'hFFFD, 16'd2, 1);
    cyc(0, 2, 1, 16'd4, 16'd0, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd5) begin
      bad++;
      $display("FAIL basic_first valid=%b y=%h want 1/0005", valid_y_out, y_out);
    end
    cyc(0, 2, 1, 16'hFFF8, 16'hFFFF, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd2) begin
      bad++;
      $display("FAIL basic_second valid=%b y=%h want 1/0002", valid_y_out, y_out);
    end
    cyc(0, 2, 0, 16'h0, 16'h0, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain valid=%b want 0", valid_y_out);
    end
  endtask

  task automatic test_signed();
    cyc(1, 1, 1, 16'h8000, 16'hFFFF, 1);
    cyc(0, 1, 1, 16'h8000, 16'h8000, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'hFFFF) begin
      bad++;
      $display("FAIL signed_max valid=%b y=%h want 1/ffff", valid_y_out, y_out);
    end
    cyc(0, 1, 0, 16'h0, 16'h0, 1);
  endtask

  task automatic test_drop();
    cyc(1, 3, 1, 16'd1, 16'd0, 0);
    cyc(0, 3, 1, 16'd2, 16'd0, 0);
    cyc(0, 3, 1, 16'd3, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 0);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd1) begin
      bad++;
      $display("FAIL drop_head valid=%b y=%h want 1/0001", valid_y_out, y_out);
    end
    total++;
    if (drop_cnt !== EXP_DROP) begin
      bad++;
      $display("FAIL drop_count got=%h want=%h", drop_cnt, EXP_DROP);
    end
    cyc(0, 3, 0, 16'h0, 16'h0, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd2) begin
      bad++;
      $display("FAIL drop_second valid=%b y=%h want 1/0002", valid_y_out, y_out);
    end
    cyc(0, 3, 0, 16'h0, 16'h0, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL drop_empty valid=%b want 0", valid_y_out);
    end
  endtask

  task automatic test_full_pop_push();
    cyc(1, 3, 1, 16'd10, 16'd0, 0);
    cyc(0, 3, 1, 16'd20, 16'd0, 0);
    cyc(0, 3, 1, 16'd30, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 0);
    cyc(0, 3, 1, 16'd0, 16'd0, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd20) begin
      bad++;
      $display("FAIL fullpp_head valid=%b y=%h want 1/0014", valid_y_out, y_out);
    end
    total++;
    if (drop_cnt !== EXP_DROP) begin
      bad++;
      $display("FAIL fullpp_drop got=%h want=%h", drop_cnt, EXP_DROP);
    end
    cyc(0, 3, 0, 16'h0, 16'h0, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd30) begin
      bad++;
      $display("FAIL fullpp_pushed valid=%b y=%h want 1/001e", valid_y_out, y_out);
    end
    cyc(0, 3, 0, 16'h0, 16'h0, 1);
  endtask

  task automatic test_start_len0();
    cyc(1, 0, 1, 16'd3, 16'd9, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL len0_even1 valid=%b want 0", valid_y_out);
    end
    cyc(0, 0, 1, 16'd1, 16'd2, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd9) begin
      bad++;
      $display("FAIL len0_odd1 valid=%b y=%h want 1/0009", valid_y_out, y_out);
    end
    cyc(0, 0, 1, 16'hFFFB, 16'hFFFA, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL len0_even2 valid=%b want 0", valid_y_out);
    end
    cyc(0, 0, 1, 16'hFFF9, 16'hFFF7, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'hFFFB) begin
      bad++;
      $display("FAIL len0_odd2 valid=%b y=%h want 1/fffb", valid_y_out, y_out);
    end
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 64; i++) begin
      cyc((i == 0), 8'd200, 1, 16'(i), 16'd0, 1);
    end
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL clamp_even valid=%b want 0", valid_y_out);
    end
    cyc(0, 8'd200, 1, 16'hFFFF, 16'hFFFF, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd0) begin
      bad++;
      $display("FAIL clamp_odd valid=%b y=%h want 1/0000", valid_y_out, y_out);
    end
    cyc(0, 8'd200, 0, 16'h0, 16'h0, 1);
  endtask

  task automatic test_reset_mid();
    cyc(1, 2, 1, 16'd1, 16'd0, 0);
    cyc(0, 2, 1, 16'd2, 16'd0, 0);
    cyc(0, 2, 1, 16'd0, 16'd0, 0);
    total++;
    if (valid_y_out !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre valid=%b want 1", valid_y_out);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (valid_y_out !== 1'b0 || y_out !== 16'h0 || drop_cnt !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_async valid=%b y=%h drop=%h want 0/0000/0000", valid_y_out, y_out, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    cyc(0, 2, 1, 16'd7, 16'd0, 1);
    total++;
    if (valid_y_out !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_even valid=%b want 0", valid_y_out);
    end
    cyc(0, 2, 1, 16'd0, 16'd0, 1);
    total++;
    if (valid_y_out !== 1'b1 || y_out !== 16'd7) begin
      bad++;
      $display("FAIL rstmid_odd valid=%b y=%h want 1/0007", valid_y_out, y_out);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b1;
    start       = 1'b0;
    row_len     = 8'd0;
    y_in        = '0;
    valid_y_in  = 1'b0;
    ready_y_out = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_drop();
    test_full_pop_push();
    test_start_len0();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
